// File: rtl/interp_window_feeder.sv
// rtl/interp_window_feeder.sv - 8-tap sliding window feeder with edge replication
// Turns a raster sample stream into one packed interpolation window per output position.
module interp_window_feeder #(
  parameter int SAMPLE_W = 8,
  parameter int TAPS     = 8,
  parameter int ROW_LEN  = 64,
  parameter int POS_W    = $clog2(ROW_LEN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SAMPLE_W-1:0]        in_sample,
  input  logic                       in_last,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [TAPS*SAMPLE_W-1:0]   win_data,
  output logic [POS_W-1:0]           win_pos,
  output logic                       win_last,
  output logic                       row_err
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  localparam logic [POS_W:0] ROW_MAX = (POS_W+1)'(ROW_LEN);

  state_t              state;
  logic [SAMPLE_W-1:0] win_buf [TAPS];
  logic [2:0]          c;
  logic [2:0]          d;
  logic [POS_W:0]      n;

  logic                out_free;
  logic                accept;
  logic                overflow;
  logic                row_end;
  logic                drain_shift;
  logic [2:0]          c_inc;
  logic [POS_W:0]      n_inc;

  assign out_free    = !win_valid || win_ready;
  assign in_ready    = !reset && (state == IDLE || state == FILL ||
                                  (state == STREAM && out_free));
  assign accept      = in_valid && in_ready;
  assign n_inc       = (state == IDLE) ? (POS_W+1)'(1) : n + (POS_W+1)'(1);
  assign overflow    = (n_inc == ROW_MAX);
  assign row_end     = in_last || overflow;
  assign row_err     = accept && overflow && !in_last;
  // c only has to tell "window ready" apart, so it saturates at 4
  assign c_inc       = (c >= 3'd4) ? 3'd4 : c + 3'd1;
  assign drain_shift = (state == DRAIN) && (d < 3'd4) && out_free;

  genvar gk;
  generate
    for (gk = 0; gk < TAPS; gk++) begin : g_pack
      assign win_data[gk*SAMPLE_W +: SAMPLE_W] = win_buf[gk];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int i = 0; i < TAPS; i++) win_buf[i] <= '0;
      c         <= '0;
      d         <= '0;
      n         <= '0;
      win_valid <= 1'b0;
      win_pos   <= '0;
      win_last  <= 1'b0;
    end else begin
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_pos   <= win_pos + POS_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            // left-edge replication: older taps hold s(0) until shifted out
            for (int i = 0; i < TAPS; i++) win_buf[i] <= in_sample;
            c       <= '0;
            d       <= '0;
            n       <= n_inc;
            win_pos <= '0;
            state   <= row_end ? DRAIN : FILL;
          end
        end
        FILL, STREAM: begin
          if (accept) begin
            for (int i = TAPS-1; i > 0; i--) win_buf[i] <= win_buf[i-1];
            win_buf[0] <= in_sample;
            c <= c_inc;
            n <= n_inc;
            if (c_inc == 3'd4) begin
              win_valid <= 1'b1;
              win_last  <= 1'b0;
            end
            if (row_end) begin
              d     <= '0;
              state <= DRAIN;
            end else if (c_inc == 3'd4) begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_shift) begin
            // right-edge replication: keep feeding the last accepted sample
            for (int i = TAPS-1; i > 0; i--) win_buf[i] <= win_buf[i-1];
            win_buf[0] <= win_buf[0];
            c <= c_inc;
            d <= d + 3'd1;
            if (c_inc == 3'd4) begin
              win_valid <= 1'b1;
              win_last  <= (d == 3'd3);
            end
          end else if (d == 3'd4 && win_valid && win_ready) begin
            state    <= IDLE;
            win_pos  <= '0;
            win_last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_window_feeder.sv
// tb/tb_interp_window_feeder.sv - directed bench for interp_window_feeder
module tb_interp_window_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_sample = '0;
  logic        in_last = 1'b0;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [63:0] win_data;
  logic [5:0]  win_pos;
  logic        win_last;
  logic        row_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] wq_data[$];
  int          wq_pos[$];
  logic        wq_last[$];
  int          wq_cyc[$];
  int          acc_cyc[$];
  int          err_idx[$];
  int          acc_n = 0;
  int          stray_err = 0;
  logic [7:0]  exp_s[$];

  interp_window_feeder #(.SAMPLE_W(8), .TAPS(8), .ROW_LEN(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .in_last(in_last),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_pos(win_pos), .win_last(win_last), .row_err(row_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (win_valid && win_ready) begin
        wq_data.push_back(win_data);
        wq_pos.push_back(int'(win_pos));
        wq_last.push_back(win_last);
        wq_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        acc_n = acc_n + 1;
        acc_cyc.push_back(cyc);
        if (row_err) err_idx.push_back(acc_n);
      end else if (row_err) begin
        stray_err = stray_err + 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(input int st, input int n, input int p);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 4 - k;
      if (idx < 0) idx = 0;
      if (idx > n - 1) idx = n - 1;
      r[k*8 +: 8] = exp_s[st + idx];
    end
    return r;
  endfunction

  task automatic clear_logs();
    wq_data.delete(); wq_pos.delete(); wq_last.delete(); wq_cyc.delete();
    acc_cyc.delete(); err_idx.delete(); exp_s.delete();
    acc_n = 0;
    stray_err = 0;
  endtask

  task automatic send(input logic [7:0] s, input logic last);
    int t;
    in_valid = 1'b1; in_sample = s; in_last = last; t = 0;
    exp_s.push_back(s);
    @(negedge clock);
    while (!in_ready && t < 200) begin @(negedge clock); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept got in_ready=%b want 1", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_sample = 8'h55; win_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL rst_win_valid got %b want 0", win_valid); end
    checks++; if (win_data !== 64'h0) begin errors++; $display("FAIL rst_win_data got %h want 0", win_data); end
    checks++; if (win_pos !== 6'd0) begin errors++; $display("FAIL rst_win_pos got %0d want 0", win_pos); end
    checks++; if (win_last !== 1'b0) begin errors++; $display("FAIL rst_win_last got %b want 0", win_last); end
    checks++; if (row_err !== 1'b0) begin errors++; $display("FAIL rst_row_err got %b want 0", row_err); end
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ramp();
    int t;
    clear_logs();
    @(posedge clock); #1;
    win_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(10 + i), i == 7);
    t = 0;
    while (wq_data.size() < 8 && t < 60) begin @(negedge clock); t++; end
    repeat (6) @(negedge clock);
    checks++;
    if (wq_data.size() != 8) begin errors++; $display("FAIL ramp_count got %0d want 8", wq_data.size()); end
    if (wq_data.size() == 8) begin
      checks++;
      if (wq_data[0] !== 64'h0A0A0A0A0B0C0D0E) begin errors++; $display("FAIL ramp_p0 got %h want 0a0a0a0a0b0c0d0e", wq_data[0]); end
      checks++;
      if (wq_data[7] !== 64'h0E0F101111111111) begin errors++; $display("FAIL ramp_p7 got %h want 0e0f101111111111", wq_data[7]); end
      checks++;
      if (wq_cyc[0] != acc_cyc[4] + 1) begin errors++; $display("FAIL ramp_latency got %0d want %0d", wq_cyc[0], acc_cyc[4] + 1); end
    end
    for (int p = 0; p < 8 && p < wq_data.size(); p++) begin
      checks++;
      if (wq_data[p] !== model(0, 8, p) || wq_pos[p] != p || wq_last[p] !== (p == 7)) begin
        errors++;
        $display("FAIL ramp_win p=%0d got %h/%0d/%b want %h/%0d/%b", p, wq_data[p], wq_pos[p], wq_last[p], model(0, 8, p), p, p == 7);
      end
    end
  endtask

  task automatic test_single();
    int i;
    int lowfail;
    clear_logs();
    @(posedge clock); #1;
    win_ready = 1'b1;
    send(8'd42, 1'b1);
    i = 0; lowfail = 0;
    while (i < 12) begin
      @(negedge clock); i++;
      if (in_ready !== 1'b0) lowfail++;
      if (win_valid === 1'b1) break;
    end
    checks++; if (i != 5) begin errors++; $display("FAIL single_latency got %0d want 5", i); end
    checks++; if (lowfail != 0) begin errors++; $display("FAIL single_drain_ready got %0d high cycles want 0", lowfail); end
    repeat (8) @(negedge clock);
    checks++;
    if (wq_data.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", wq_data.size()); end
    else begin
      checks++;
      if (wq_data[0] !== 64'h2A2A2A2A2A2A2A2A || wq_pos[0] != 0 || wq_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_win got %h/%0d/%b want 2a2a2a2a2a2a2a2a/0/1", wq_data[0], wq_pos[0], wq_last[0]);
      end
    end
  endtask

  task automatic test_stall();
    logic        held;
    logic [63:0] hd;
    logic [5:0]  hp;
    logic        hl;
    logic [63:0] want [3];
    clear_logs();
    want[0] = 64'h0505050506070707;
    want[1] = 64'h0505050607070707;
    want[2] = 64'h0505060707070707;
    @(posedge clock); #1;
    held = 1'b0; hd = '0; hp = '0; hl = 1'b0;
    fork
      begin
        send(8'd5, 1'b0); send(8'd6, 1'b0); send(8'd7, 1'b1);
      end
      begin
        for (int j = 0; j < 40; j++) begin
          win_ready = (j % 3 == 0);
          @(negedge clock);
          if (held) begin
            checks++;
            if (win_valid !== 1'b1 || win_data !== hd || win_pos !== hp || win_last !== hl) begin
              errors++;
              $display("FAIL stall_hold got %b/%h/%0d/%b want 1/%h/%0d/%b", win_valid, win_data, win_pos, win_last, hd, hp, hl);
            end
          end
          held = win_valid && !win_ready;
          hd = win_data; hp = win_pos; hl = win_last;
          @(posedge clock); #1;
        end
        win_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clock);
    checks++;
    if (wq_data.size() != 3) begin errors++; $display("FAIL stall_count got %0d want 3", wq_data.size()); end
    for (int p = 0; p < 3 && p < wq_data.size(); p++) begin
      checks++;
      if (wq_data[p] !== want[p] || wq_pos[p] != p || wq_last[p] !== (p == 2)) begin
        errors++;
        $display("FAIL stall_win p=%0d got %h/%0d/%b want %h/%0d/%b", p, wq_data[p], wq_pos[p], wq_last[p], want[p], p, p == 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int breaks;
    int gap;
    clear_logs();
    @(posedge clock); #1;
    win_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) send(8'((r == 0 ? 100 : 200) + i), i == 15);
    t = 0;
    while (wq_data.size() < 32 && t < 100) begin @(negedge clock); t++; end
    repeat (8) @(negedge clock);
    checks++;
    if (wq_data.size() != 32) begin errors++; $display("FAIL b2b_count got %0d want 32", wq_data.size()); end
    breaks = 0;
    for (int w = 0; w < 32 && w < wq_data.size(); w++) begin
      checks++;
      if (wq_data[w] !== model((w / 16) * 16, 16, w % 16) || wq_pos[w] != w % 16 || wq_last[w] !== (w % 16 == 15)) begin
        errors++;
        $display("FAIL b2b_win w=%0d got %h/%0d/%b want %h/%0d/%b", w, wq_data[w], wq_pos[w], wq_last[w],
                 model((w / 16) * 16, 16, w % 16), w % 16, w % 16 == 15);
      end
      if (w % 16 != 0 && wq_cyc[w] != wq_cyc[w-1] + 1) breaks++;
    end
    checks++;
    if (breaks != 0) begin errors++; $display("FAIL b2b_rate got %0d bubbles want 0", breaks); end
    if (acc_cyc.size() == 32) begin
      gap = acc_cyc[16] - acc_cyc[15] - 1;
      checks++;
      if (gap < 4) begin errors++; $display("FAIL b2b_gap got %0d want >=4", gap); end
    end
  endtask

  task automatic test_overflow();
    int t;
    clear_logs();
    @(posedge clock); #1;
    win_ready = 1'b1;
    for (int i = 1; i <= 70; i++) send(8'(i), 1'b0);
    t = 0;
    while (wq_data.size() < 66 && t < 200) begin @(negedge clock); t++; end
    repeat (10) @(negedge clock);
    checks++;
    if (err_idx.size() != 1) begin errors++; $display("FAIL ovf_err_count got %0d want 1", err_idx.size()); end
    else begin
      checks++;
      if (err_idx[0] != 64) begin errors++; $display("FAIL ovf_err_at got %0d want 64", err_idx[0]); end
    end
    checks++;
    if (stray_err != 0) begin errors++; $display("FAIL ovf_stray_err got %0d want 0", stray_err); end
    checks++;
    if (acc_n != 70) begin errors++; $display("FAIL ovf_accepts got %0d want 70", acc_n); end
    checks++;
    if (wq_data.size() != 66) begin errors++; $display("FAIL ovf_count got %0d want 66", wq_data.size()); end
    for (int w = 0; w < 66 && w < wq_data.size(); w++) begin
      checks++;
      if (w < 64) begin
        if (wq_data[w] !== model(0, 64, w) || wq_pos[w] != w || wq_last[w] !== (w == 63)) begin
          errors++;
          $display("FAIL ovf_row1 w=%0d got %h/%0d/%b want %h/%0d/%b", w, wq_data[w], wq_pos[w], wq_last[w], model(0, 64, w), w, w == 63);
        end
      end else begin
        if (wq_data[w] !== model(64, 6, w - 64) || wq_pos[w] != w - 64 || wq_last[w] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_row2 w=%0d got %h/%0d/%b want %h/%0d/0", w, wq_data[w], wq_pos[w], wq_last[w], model(64, 6, w - 64), w - 64);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_logs();
    win_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(50 + i), 1'b0);
    checks++;
    if (win_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", win_valid); end
    reset = 1'b1;
    #1;
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL mid_win_valid got %b want 0", win_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
    checks++; if (win_data !== 64'h0) begin errors++; $display("FAIL mid_win_data got %h want 0", win_data); end
    @(posedge clock); #1;
    reset = 1'b0;
    clear_logs();
    send(8'd80, 1'b0); send(8'd81, 1'b0); send(8'd82, 1'b1);
    t = 0;
    while (wq_data.size() < 3 && t < 40) begin @(negedge clock); t++; end
    repeat (8) @(negedge clock);
    checks++;
    if (wq_data.size() != 3) begin errors++; $display("FAIL mid_count got %0d want 3", wq_data.size()); end
    for (int p = 0; p < 3 && p < wq_data.size(); p++) begin
      checks++;
      if (wq_data[p] !== model(0, 3, p) || wq_pos[p] != p || wq_last[p] !== (p == 2)) begin
        errors++;
        $display("FAIL mid_win p=%0d got %h/%0d/%b want %h/%0d/%b", p, wq_data[p], wq_pos[p], wq_last[p], model(0, 3, p), p, p == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_single();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interp_window_feeder.md
Name: interp_window_feeder

Overview:
- Producer end of the sub-pel interpolation datapath.
- Accepts a raster stream of 8-bit samples, one row at a time.
- Keeps an 8-entry sliding window with edge replication at row start and row end.
- Emits one 8-sample window per output position in the packed data_buffer layout that the A/B/C tap-sum blocks consume.
- For position p, entry [4] holds s(p) and entry [3] holds s(p+1).

Parameters:
- SAMPLE_W, 8, bits per sample.
- TAPS, 8, window depth; fixed at 8, other values unsupported.
- ROW_LEN, 64, maximum samples per row; POS_W = $clog2(ROW_LEN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  feeder can accept a sample.
- in_sample  in  SAMPLE_W  sample value.
- in_last  in  1  sample is the final sample of its row.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts the window.
- win_data  out  TAPS*SAMPLE_W  packed window; win_data[k] = buf[k].
- win_pos  out  POS_W  output position p within the row.
- win_last  out  1  window is p = N-1 of the row.
- row_err  out  1  one-cycle pulse: row truncated at ROW_LEN.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; buf, shift counter c and sample counter n clear to 0.
  - win_valid=0, win_data=0, win_pos=0, win_last=0, row_err=0, in_ready=0 while reset is asserted.
  - A partial row is discarded; no window is emitted for it.
- Window mapping: buf[k] = s(clamp(p+4-k, 0, N-1)). buf[7] = s(p-3), buf[0] = s(p+4).
- Accept: in_valid & in_ready. Window handshake: win_valid & win_ready.
- Shift operation: buf[k+1] <= buf[k] for k = 0..6, buf[0] <= new value, c <= c+1.
- States:
  - IDLE: in_ready=1. On accept, buf[3:0] <= in_sample (left-edge replication, buf[7:4] don't-care), c=0, n=1. Go to DRAIN if in_last, else FILL.
  - FILL (c<4): in_ready=1. Each accept shifts, n++. When c reaches 4, win_valid rises next cycle and the state is STREAM. in_last on an accept goes to DRAIN.
  - STREAM: in_ready = !win_valid | win_ready. Each accept shifts and loads the next window. Same-cycle window handshake plus accept gives 1 window/cycle with win_valid held high. in_last goes to DRAIN.
  - DRAIN: in_ready=0. Performs exactly 4 shifts of the replicated last sample s(N-1), advancing under the same output stall rule as STREAM. After the 4th drain shift's window is handshaked, go to IDLE.
- Window emission:
  - A window is presented after every shift where the post-shift c >= 4.
  - This yields exactly N windows per row, for any N in 1..ROW_LEN.
- Latency: window p is valid the cycle after s(p+4) is accepted, or after the corresponding drain shift.
- Output stability: while win_valid & !win_ready, win_data, win_pos and win_last hold stable and no shift occurs.
- win_pos: 0 for the first window, +1 per window handshake, reset to 0 at row start.
- win_last: 1 only on the window where win_pos = N-1.
- Overflow: if n reaches ROW_LEN without in_last, that sample is treated as last.
  - row_err pulses 1 cycle coincident with that accept.
  - The next sample starts a new row.
- Row gap: a new row is accepted only in IDLE, giving a minimum 4-cycle in_ready bubble between rows.
- Reset mid-row or mid-drain: state aborts immediately; outputs go to reset values.

Test Plan:
- Ramp row N=8, samples 10..17, win_ready=1 -> 8 windows, win_pos 0..7. p=0 buf[7..0] = 10,10,10,10,11,12,13,14, valid the cycle after the 5th accept. p=7 = 14,15,16,17,17,17,17,17 with win_last=1.
- Single-sample row 42 with in_last -> exactly one window, all entries 42, win_pos=0, win_last=1, emitted after 4 drain cycles; in_ready=0 during drain.
- N=3 row 5,6,7 with win_ready toggling 1,0,0,1,... -> windows 5,5,5,5,6,7,7,7 / 5,5,5,6,7,7,7,7 / 5,5,6,7,7,7,7,7 in order, each held stable while stalled; no sample lost or duplicated.
- 70 samples without in_last (ROW_LEN=64) -> row_err pulses on the 64th accept, 64 windows with the last having win_last=1. Samples 65..70 start row 2, which is held pending until its in_last.
- Reset asserted after the 6th accept of a 10-sample row -> win_valid drops immediately, in_ready=0 during reset. After release a fresh 3-sample row yields exactly 3 windows with no stale data.
- Back-to-back rows of N=16, continuous in_valid, win_ready=1 -> 1 window/cycle in STREAM, exactly 16 windows per row, 4-cycle in_ready gap between rows.
